// File: rtl/lead_zero_normalizer.sv
// Sequential leading-zero normaliser: shifts the operand left one bit per cycle
// until its MSB is set, reporting the truncated normalised value and shift count.
module lead_zero_normalizer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] top_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [OUT_W-1:0] top_out_n;
  logic [CNT_W-1:0] shift_cnt_n;
  logic             zero_flag_n;
  logic             busy_n;
  logic             done_n;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      top_out   <= '0;
      shift_cnt <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      top_out   <= top_out_n;
      shift_cnt <= shift_cnt_n;
      zero_flag <= zero_flag_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output logic; results are held until the next accepted start
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    top_out_n   = top_out;
    shift_cnt_n = shift_cnt;
    zero_flag_n = zero_flag;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (op_in != '0) begin
            sr_n        = op_in;
            cnt_n       = '0;
            zero_flag_n = 1'b0;
            state_n     = SHIFT;
          end else begin
            sr_n        = '0;
            cnt_n       = CNT_W'(WIDTH);
            top_out_n   = '0;
            shift_cnt_n = CNT_W'(WIDTH);
            zero_flag_n = 1'b1;
            state_n     = DONE;
          end
        end
      end
      SHIFT: begin
        if (sr[WIDTH-1]) begin
          top_out_n   = sr[WIDTH-1 -: OUT_W];
          shift_cnt_n = cnt;
          state_n     = DONE;
        end else begin
          sr_n  = {sr[WIDTH-2:0], 1'b0};
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_lead_zero_normalizer.sv
// Directed testbench for lead_zero_normalizer with hand-computed expectations.
module tb_lead_zero_normalizer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_in;
  logic        busy;
  logic        done;
  logic [7:0]  top_out;
  logic [4:0]  shift_cnt;
  logic        zero_flag;

  int total = 0;
  int bad   = 0;
  int n;

  lead_zero_normalizer #(.WIDTH(16), .OUT_W(8), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_in     (op_in),
    .busy      (busy),
    .done      (done),
    .top_out   (top_out),
    .shift_cnt (shift_cnt),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Step until done is seen, counting edges; an expired budget counts as a failure
  task automatic wait_done(inout int cnt);
    int guard;
    guard = 0;
    while (!done && guard < 40) begin
      step();
      cnt++;
      guard++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  // Present an operand with a one-cycle start pulse; returns after the accepting edge
  task automatic launch(input logic [15:0] v);
    op_in = v;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_in = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_top", 32'(top_out), 32'd0);
    chk("rst_cnt", 32'(shift_cnt), 32'd0);
    chk("rst_zf", 32'(zero_flag), 32'd0);
    rst = 1'b0;
    step();

    // 1: already normalised
    launch(16'h8000);
    chk("t1_busy", 32'(busy), 32'd1);
    n = 0;
    wait_done(n);
    chk("t1_lat", 32'(n), 32'd1);
    chk("t1_cnt", 32'(shift_cnt), 32'd0);
    chk("t1_top", 32'(top_out), 32'h80);
    chk("t1_zf", 32'(zero_flag), 32'd0);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: maximum shift count
    launch(16'h0001);
    n = 0;
    wait_done(n);
    chk("t2_lat", 32'(n), 32'd16);
    chk("t2_cnt", 32'(shift_cnt), 32'd15);
    chk("t2_top", 32'(top_out), 32'h80);
    step();
    step();
    chk("t2_hold_cnt", 32'(shift_cnt), 32'd15);

    // 3: zero operand skips SHIFT
    launch(16'h0000);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_zf", 32'(zero_flag), 32'd1);
    chk("t3_cnt", 32'(shift_cnt), 32'd16);
    chk("t3_top", 32'(top_out), 32'h00);
    step();

    // 4: start while busy is ignored
    launch(16'h00B7);
    chk("t4_zf_clr", 32'(zero_flag), 32'd0);
    n = 0;
    step(); step(); step();
    n = 3;
    op_in = 16'hFFFF;
    start = 1'b1;
    step();
    n++;
    start = 1'b0;
    wait_done(n);
    chk("t4_lat", 32'(n), 32'd9);
    chk("t4_cnt", 32'(shift_cnt), 32'd8);
    chk("t4_top", 32'(top_out), 32'hB7);
    step();
    step();
    chk("t4_no_restart", 32'(busy), 32'd0);

    // 5: reset mid-operation
    launch(16'h0010);
    step(); step(); step();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_top", 32'(top_out), 32'd0);
    chk("t5_cnt", 32'(shift_cnt), 32'd0);
    launch(16'h4000);
    n = 0;
    wait_done(n);
    chk("t5b_lat", 32'(n), 32'd2);
    chk("t5b_cnt", 32'(shift_cnt), 32'd1);
    chk("t5b_top", 32'(top_out), 32'h80);
    step();

    // 6: start held high across two operands
    op_in = 16'h0300;
    start = 1'b1;
    step();
    op_in = 16'h8001;
    n = 0;
    wait_done(n);
    chk("t6a_lat", 32'(n), 32'd7);
    chk("t6a_cnt", 32'(shift_cnt), 32'd6);
    chk("t6a_top", 32'(top_out), 32'hC0);
    step();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_done", 32'(done), 32'd0);
    step();
    chk("t6b_busy", 32'(busy), 32'd1);
    chk("t6b_nodone", 32'(done), 32'd0);
    step();
    start = 1'b0;
    chk("t6b_done", 32'(done), 32'd1);
    chk("t6b_cnt", 32'(shift_cnt), 32'd0);
    chk("t6b_top", 32'(top_out), 32'h80);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
